// File: rtl/issue_pkg.sv
// Shared issue-stage package: physical register sizing and the types used by
// the busy table and the issue slots.
package issue_pkg;

    localparam int NUM_PREGS = 128;
    localparam int PREG_W    = 7;
    localparam int CNT_W     = PREG_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Widen a single event flag so it can be summed into a count.
    function automatic cnt_t flag_to_cnt(input logic flag);
        return cnt_t'(flag);
    endfunction

endpackage

// File: rtl/busy_read_port.sv
// busy_read_port: looks up one source preg in the busy vector, with
// same-cycle wakeup bypass (a preg being woken this cycle reads not busy).
//   i_prs       source preg to look up
//   i_busy      current busy vector
//   i_wk0_*     wakeup port 0 (valid, pdst)
//   i_wk1_*     wakeup port 1 (valid, pdst)
//   o_busy      resulting busy bit
module busy_read_port
    import issue_pkg::*;
(
    input  preg_t                 i_prs,
    input  logic [NUM_PREGS-1:0]  i_busy,
    input  logic                  i_wk0_valid,
    input  preg_t                 i_wk0_pdst,
    input  logic                  i_wk1_valid,
    input  preg_t                 i_wk1_pdst,
    output logic                  o_busy
);

    logic w_wk0_hit;
    logic w_wk1_hit;

    assign w_wk0_hit = i_wk0_valid && (i_wk0_pdst == i_prs);
    assign w_wk1_hit = i_wk1_valid && (i_wk1_pdst == i_prs);
    assign o_busy    = i_busy[i_prs] && !w_wk0_hit && !w_wk1_hit;

endmodule

// File: rtl/busy_table.sv
// busy_table: per-preg pending flags for rename/dispatch. Two micro-ops per
// cycle read their three sources (zero latency) and may allocate a
// destination; two wakeup ports clear flags. Also keeps an exact count of
// busy pregs, updated incrementally.
//   clk, reset                 clock, synchronous active-high reset
//   io_ren_uops_{0,1}_*        dispatch slots (valid, ldst_val, pdst, prs1..3)
//   io_wakeup_ports_{0,1}_*    wakeup ports (valid, bits_pdst)
//   io_busy_resps_{0,1}_*      per-source busy bits for each slot
//   io_busy_count              registered number of busy pregs
module busy_table
    import issue_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   io_ren_uops_0_valid,
    input  logic   io_ren_uops_0_ldst_val,
    input  preg_t  io_ren_uops_0_pdst,
    input  preg_t  io_ren_uops_0_prs1,
    input  preg_t  io_ren_uops_0_prs2,
    input  preg_t  io_ren_uops_0_prs3,
    input  logic   io_ren_uops_1_valid,
    input  logic   io_ren_uops_1_ldst_val,
    input  preg_t  io_ren_uops_1_pdst,
    input  preg_t  io_ren_uops_1_prs1,
    input  preg_t  io_ren_uops_1_prs2,
    input  preg_t  io_ren_uops_1_prs3,
    input  logic   io_wakeup_ports_0_valid,
    input  preg_t  io_wakeup_ports_0_bits_pdst,
    input  logic   io_wakeup_ports_1_valid,
    input  preg_t  io_wakeup_ports_1_bits_pdst,
    output logic   io_busy_resps_0_prs1_busy,
    output logic   io_busy_resps_0_prs2_busy,
    output logic   io_busy_resps_0_prs3_busy,
    output logic   io_busy_resps_1_prs1_busy,
    output logic   io_busy_resps_1_prs2_busy,
    output logic   io_busy_resps_1_prs3_busy,
    output cnt_t   io_busy_count
);

    logic [NUM_PREGS-1:0] r_busy;
    cnt_t                 r_count;

    logic [NUM_PREGS-1:0] w_busy_next;
    logic                 w_alloc0, w_alloc1, w_wake0, w_wake1;
    logic                 w_rise0, w_rise1, w_fall0, w_fall1;
    preg_t                w_srcs [6];
    logic  [5:0]          w_rd;

    // Preg 0 is never tracked, so every event on it is dropped here.
    assign w_alloc0 = io_ren_uops_0_valid && io_ren_uops_0_ldst_val && (io_ren_uops_0_pdst != '0);
    assign w_alloc1 = io_ren_uops_1_valid && io_ren_uops_1_ldst_val && (io_ren_uops_1_pdst != '0);
    assign w_wake0  = io_wakeup_ports_0_valid && (io_wakeup_ports_0_bits_pdst != '0);
    assign w_wake1  = io_wakeup_ports_1_valid && (io_wakeup_ports_1_bits_pdst != '0);

    assign w_srcs[0] = io_ren_uops_0_prs1;
    assign w_srcs[1] = io_ren_uops_0_prs2;
    assign w_srcs[2] = io_ren_uops_0_prs3;
    assign w_srcs[3] = io_ren_uops_1_prs1;
    assign w_srcs[4] = io_ren_uops_1_prs2;
    assign w_srcs[5] = io_ren_uops_1_prs3;

    for (genvar g = 0; g < 6; g++) begin : g_rd
        busy_read_port u_rd (
            .i_prs       (w_srcs[g]),
            .i_busy      (r_busy),
            .i_wk0_valid (io_wakeup_ports_0_valid),
            .i_wk0_pdst  (io_wakeup_ports_0_bits_pdst),
            .i_wk1_valid (io_wakeup_ports_1_valid),
            .i_wk1_pdst  (io_wakeup_ports_1_bits_pdst),
            .o_busy      (w_rd[g])
        );
    end

    // Slot 1 sources also see slot 0's new destination; the new producer
    // takes priority over a same-cycle wakeup of the old value. Responses
    // are forced low while reset is held.
    assign io_busy_resps_0_prs1_busy = !reset && w_rd[0];
    assign io_busy_resps_0_prs2_busy = !reset && w_rd[1];
    assign io_busy_resps_0_prs3_busy = !reset && w_rd[2];
    assign io_busy_resps_1_prs1_busy = !reset && (w_rd[3] || (w_alloc0 && io_ren_uops_1_prs1 == io_ren_uops_0_pdst));
    assign io_busy_resps_1_prs2_busy = !reset && (w_rd[4] || (w_alloc0 && io_ren_uops_1_prs2 == io_ren_uops_0_pdst));
    assign io_busy_resps_1_prs3_busy = !reset && (w_rd[5] || (w_alloc0 && io_ren_uops_1_prs3 == io_ren_uops_0_pdst));

    // Wakeups clear first, then allocations set, so allocation wins a collision.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wake0)  w_busy_next[io_wakeup_ports_0_bits_pdst] = 1'b0;
        if (w_wake1)  w_busy_next[io_wakeup_ports_1_bits_pdst] = 1'b0;
        if (w_alloc0) w_busy_next[io_ren_uops_0_pdst] = 1'b1;
        if (w_alloc1) w_busy_next[io_ren_uops_1_pdst] = 1'b1;
    end

    // Real 0->1 and 1->0 transitions only: duplicates within the cycle,
    // allocations of already-busy pregs and wakeups of idle pregs (or of a
    // preg re-allocated this cycle) do not move the count.
    assign w_rise0 = w_alloc0 && !r_busy[io_ren_uops_0_pdst];
    assign w_rise1 = w_alloc1 && !r_busy[io_ren_uops_1_pdst] &&
                     !(w_alloc0 && io_ren_uops_0_pdst == io_ren_uops_1_pdst);
    assign w_fall0 = w_wake0 && r_busy[io_wakeup_ports_0_bits_pdst] &&
                     !(w_alloc0 && io_ren_uops_0_pdst == io_wakeup_ports_0_bits_pdst) &&
                     !(w_alloc1 && io_ren_uops_1_pdst == io_wakeup_ports_0_bits_pdst);
    assign w_fall1 = w_wake1 && r_busy[io_wakeup_ports_1_bits_pdst] &&
                     !(w_wake0 && io_wakeup_ports_0_bits_pdst == io_wakeup_ports_1_bits_pdst) &&
                     !(w_alloc0 && io_ren_uops_0_pdst == io_wakeup_ports_1_bits_pdst) &&
                     !(w_alloc1 && io_ren_uops_1_pdst == io_wakeup_ports_1_bits_pdst);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_count <= r_count + flag_to_cnt(w_rise0) + flag_to_cnt(w_rise1)
                               - flag_to_cnt(w_fall0) - flag_to_cnt(w_fall1);
        end
    end

    assign io_busy_count = r_count;

endmodule

// File: tb/tb_busy_table.sv
module tb_busy_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       u0v, u0l, u1v, u1l, w0v, w1v;
    logic [6:0] u0pd, u0s1, u0s2, u0s3, u1pd, u1s1, u1s2, u1s3, w0p, w1p;
    logic       r0p1, r0p2, r0p3, r1p1, r1p2, r1p3;
    logic [7:0] cnt;
    logic [5:0] dut_resp;

    typedef struct packed {
        logic [5:0] resp;
        logic [7:0] cnt;
    } sb_t;

    sb_t exp_q[$];
    sb_t act_q[$];
    bit  mbusy [128];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    assign dut_resp = {r1p3, r1p2, r1p1, r0p3, r0p2, r0p1};

    busy_table dut (
        .clk                         (clk),
        .reset                       (rst),
        .io_ren_uops_0_valid         (u0v),
        .io_ren_uops_0_ldst_val      (u0l),
        .io_ren_uops_0_pdst          (u0pd),
        .io_ren_uops_0_prs1          (u0s1),
        .io_ren_uops_0_prs2          (u0s2),
        .io_ren_uops_0_prs3          (u0s3),
        .io_ren_uops_1_valid         (u1v),
        .io_ren_uops_1_ldst_val      (u1l),
        .io_ren_uops_1_pdst          (u1pd),
        .io_ren_uops_1_prs1          (u1s1),
        .io_ren_uops_1_prs2          (u1s2),
        .io_ren_uops_1_prs3          (u1s3),
        .io_wakeup_ports_0_valid     (w0v),
        .io_wakeup_ports_0_bits_pdst (w0p),
        .io_wakeup_ports_1_valid     (w1v),
        .io_wakeup_ports_1_bits_pdst (w1p),
        .io_busy_resps_0_prs1_busy   (r0p1),
        .io_busy_resps_0_prs2_busy   (r0p2),
        .io_busy_resps_0_prs3_busy   (r0p3),
        .io_busy_resps_1_prs1_busy   (r1p1),
        .io_busy_resps_1_prs2_busy   (r1p2),
        .io_busy_resps_1_prs3_busy   (r1p3),
        .io_busy_count               (cnt)
    );

    // Reference model: expected busy bit for one source.
    function automatic logic mrd(input logic [6:0] s, input logic slot1);
        logic b;
        b = mbusy[s] && !(w0v && w0p == s) && !(w1v && w1p == s);
        if (slot1 && u0v && u0l && u0pd == s && s != 7'd0) b = 1'b1;
        if (rst) b = 1'b0;
        return b;
    endfunction

    function automatic logic [7:0] mcount();
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < 128; i++) c = c + {7'd0, mbusy[i]};
        return c;
    endfunction

    task automatic idle();
        rst = 1'b0;
        u0v = 0; u0l = 0; u0pd = 0; u0s1 = 0; u0s2 = 0; u0s3 = 0;
        u1v = 0; u1l = 0; u1pd = 0; u1s1 = 0; u1s2 = 0; u1s3 = 0;
        w0v = 0; w0p = 0; w1v = 0; w1p = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Push expectation for the current inputs, capture DUT at negedge,
    // then advance the model across the coming edge.
    task automatic eval();
        sb_t e;
        sb_t a;
        e.resp = {mrd(u1s3, 1'b1), mrd(u1s2, 1'b1), mrd(u1s1, 1'b1),
                  mrd(u0s3, 1'b0), mrd(u0s2, 1'b0), mrd(u0s1, 1'b0)};
        e.cnt  = mcount();
        exp_q.push_back(e);
        @(negedge clk);
        a.resp = dut_resp;
        a.cnt  = cnt;
        act_q.push_back(a);
        if (rst) begin
            for (int i = 0; i < 128; i++) mbusy[i] = 1'b0;
        end else begin
            if (w0v && w0p != 0) mbusy[w0p] = 1'b0;
            if (w1v && w1p != 0) mbusy[w1p] = 1'b0;
            if (u0v && u0l && u0pd != 0) mbusy[u0pd] = 1'b1;
            if (u1v && u1l && u1pd != 0) mbusy[u1pd] = 1'b1;
        end
    endtask

    task automatic test_reset();
        sb_t e, a;
        next(); rst = 1'b1;
        u0v = 1; u0l = 1; u0pd = 7'd5; u1s1 = 7'd5;
        eval();
        n_checks++;
        if (dut_resp !== 6'd0) begin n_fail++; $display("FAIL reset_resp got %b exp 000000", dut_resp); end
        next(); u0s1 = 7'd5;
        eval();
        n_checks++;
        if (r0p1 !== 1'b0) begin n_fail++; $display("FAIL reset_prs1 got %b exp 0", r0p1); end
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_reset_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_reset_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    task automatic test_alloc_wakeup();
        sb_t e, a;
        next(); u0v = 1; u0l = 1; u0pd = 7'd5;
        eval();
        next(); u0s1 = 7'd5;
        eval();
        n_checks++;
        if (r0p1 !== 1'b1) begin n_fail++; $display("FAIL alloc_prs1 got %b exp 1", r0p1); end
        n_checks++;
        if (cnt !== 8'd1) begin n_fail++; $display("FAIL alloc_count got %0d exp 1", cnt); end
        next(); u0s1 = 7'd5;
        eval();
        next(); w0v = 1; w0p = 7'd5; u0s1 = 7'd5;
        eval();
        n_checks++;
        if (r0p1 !== 1'b0) begin n_fail++; $display("FAIL bypass_prs1 got %b exp 0", r0p1); end
        next();
        eval();
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL wake_count got %0d exp 0", cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_alloc_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_alloc_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    task automatic test_intra_bundle();
        sb_t e, a;
        next(); u0v = 1; u0l = 1; u0pd = 7'd9; u0s1 = 7'd9; u1v = 1; u1s2 = 7'd9;
        eval();
        n_checks++;
        if (r1p2 !== 1'b1) begin n_fail++; $display("FAIL intra_s1prs2 got %b exp 1", r1p2); end
        n_checks++;
        if (r0p1 !== 1'b0) begin n_fail++; $display("FAIL intra_s0prs1 got %b exp 0", r0p1); end
        // 9 is busy now: slot 0 re-allocates it while port 0 wakes it.
        next(); u0v = 1; u0l = 1; u0pd = 7'd9; w0v = 1; w0p = 7'd9;
        u0s3 = 7'd9; u1s3 = 7'd9;
        eval();
        n_checks++;
        if (r1p3 !== 1'b1) begin n_fail++; $display("FAIL intra_over_wake got %b exp 1", r1p3); end
        n_checks++;
        if (r0p3 !== 1'b0) begin n_fail++; $display("FAIL intra_s0_wake got %b exp 0", r0p3); end
        next(); w1v = 1; w1p = 7'd9;
        eval();
        next();
        eval();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_intra_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_intra_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    task automatic test_collision();
        sb_t e, a;
        next(); u0v = 1; u0l = 1; u0pd = 7'd12;
        eval();
        next(); w0v = 1; w0p = 7'd12; u1v = 1; u1l = 1; u1pd = 7'd12;
        eval();
        next(); u0s1 = 7'd12;
        eval();
        n_checks++;
        if (r0p1 !== 1'b1) begin n_fail++; $display("FAIL coll_busy12 got %b exp 1", r0p1); end
        n_checks++;
        if (cnt !== 8'd1) begin n_fail++; $display("FAIL coll_count got %0d exp 1", cnt); end
        next(); u0v = 1; u0l = 1; u0pd = 7'd30; u1v = 1; u1l = 1; u1pd = 7'd30;
        eval();
        next();
        eval();
        n_checks++;
        if (cnt !== 8'd2) begin n_fail++; $display("FAIL dup_alloc_count got %0d exp 2", cnt); end
        next(); w0v = 1; w0p = 7'd30; w1v = 1; w1p = 7'd30;
        eval();
        next(); w0v = 1; w0p = 7'd12; w1v = 1; w1p = 7'd40;
        eval();
        n_checks++;
        if (cnt !== 8'd1) begin n_fail++; $display("FAIL dup_wake_count got %0d exp 1", cnt); end
        next();
        eval();
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL idle_wake_count got %0d exp 0", cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_coll_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_coll_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    task automatic test_preg0();
        sb_t e, a;
        next(); u0v = 1; u0l = 1; u0pd = 7'd0; u1v = 1; u1l = 1; u1pd = 7'd0;
        w0v = 1; w0p = 7'd0; w1v = 1; w1p = 7'd0;
        eval();
        n_checks++;
        if (dut_resp !== 6'd0) begin n_fail++; $display("FAIL p0_resp got %b exp 000000", dut_resp); end
        next();
        eval();
        n_checks++;
        if (dut_resp !== 6'd0) begin n_fail++; $display("FAIL p0_resp_next got %b exp 000000", dut_resp); end
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL p0_count got %0d exp 0", cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_p0_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_p0_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    task automatic test_count_reset();
        sb_t e, a;
        next(); u0v = 1; u0l = 1; u0pd = 7'd20; u1v = 1; u1l = 1; u1pd = 7'd21;
        eval();
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL cr_count0 got %0d exp 0", cnt); end
        next(); w0v = 1; w0p = 7'd20; w1v = 1; w1p = 7'd20; u0v = 1; u0l = 1; u0pd = 7'd21;
        eval();
        n_checks++;
        if (cnt !== 8'd2) begin n_fail++; $display("FAIL cr_count2 got %0d exp 2", cnt); end
        next(); u0s1 = 7'd21;
        eval();
        n_checks++;
        if (cnt !== 8'd1) begin n_fail++; $display("FAIL cr_count1 got %0d exp 1", cnt); end
        next(); rst = 1'b1; u0s1 = 7'd21; u1v = 1; u1l = 1; u1pd = 7'd50;
        eval();
        n_checks++;
        if (r0p1 !== 1'b0) begin n_fail++; $display("FAIL cr_resp_in_reset got %b exp 0", r0p1); end
        next(); u0s1 = 7'd21; u1s1 = 7'd21; u1s2 = 7'd50;
        eval();
        n_checks++;
        if (cnt !== 8'd0) begin n_fail++; $display("FAIL cr_count_after_reset got %0d exp 0", cnt); end
        n_checks++;
        if (dut_resp !== 6'd0) begin n_fail++; $display("FAIL cr_resp_after_reset got %b exp 000000", dut_resp); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_cr_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_cr_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    task automatic test_random();
        sb_t e, a;
        for (int c = 0; c < 400; c++) begin
            next();
            rst  = ($urandom_range(0, 59) == 0);
            u0v  = 1'($urandom); u0l = 1'($urandom); u0pd = 7'($urandom_range(0, 15));
            u1v  = 1'($urandom); u1l = 1'($urandom); u1pd = 7'($urandom_range(0, 15));
            u0s1 = 7'($urandom_range(0, 15)); u0s2 = 7'($urandom_range(0, 15)); u0s3 = 7'($urandom_range(0, 15));
            u1s1 = 7'($urandom_range(0, 15)); u1s2 = 7'($urandom_range(0, 15)); u1s3 = 7'($urandom_range(0, 15));
            w0v  = 1'($urandom); w0p = 7'($urandom_range(0, 15));
            w1v  = 1'($urandom); w1p = 7'($urandom_range(0, 15));
            eval();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            n_checks += 2;
            if (a.resp !== e.resp) begin n_fail++; $display("FAIL sb_rand_resp got %b exp %b", a.resp, e.resp); end
            if (a.cnt !== e.cnt) begin n_fail++; $display("FAIL sb_rand_count got %0d exp %0d", a.cnt, e.cnt); end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        for (int i = 0; i < 128; i++) mbusy[i] = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_alloc_wakeup();
        test_intra_bundle();
        test_collision();
        test_preg0();
        test_count_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/busy_table.md
Name: busy_table

Overview:
- Tracks, for every physical register, whether its value is still pending (busy).
- Sits upstream of the issue slots, at rename/dispatch. It supplies the prs1/prs2/prs3 busy bits that each dispatched micro-op carries into an issue slot.
- Shares the issue slots' wakeup ports, so busy bits clear in the same cycle the slots wake up.
- Handles two dispatched micro-ops per cycle, including intra-bundle dependencies. Also provides a live count of busy registers for debug and perf.

Parameters:
NUM_PREGS  128  number of physical registers
PREG_W  7  physical register specifier width, clog2(NUM_PREGS)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
io_ren_uops_0_valid  input  1  dispatch slot 0 valid
io_ren_uops_0_ldst_val  input  1  slot 0 writes a destination
io_ren_uops_0_pdst  input  PREG_W  slot 0 destination preg
io_ren_uops_0_prs1 / _prs2 / _prs3  input  PREG_W each  slot 0 source pregs
io_ren_uops_1_*  input  same set as slot 0  dispatch slot 1 (younger)
io_wakeup_ports_0_valid  input  1  wakeup port 0 valid
io_wakeup_ports_0_bits_pdst  input  PREG_W  preg becoming ready
io_wakeup_ports_1_valid / _bits_pdst  input  1 / PREG_W  wakeup port 1
io_busy_resps_0_prs1_busy / _prs2_busy / _prs3_busy  output  1 each  slot 0 source busy
io_busy_resps_1_prs1_busy / _prs2_busy / _prs3_busy  output  1 each  slot 1 source busy
io_busy_count  output  PREG_W+1  number of busy pregs, registered

Behaviour:
- State: busy vector, NUM_PREGS bits, plus count register. Reset clears all busy bits and sets count to 0. Reset mid-operation discards that cycle's allocations and wakeups. All response outputs read 0 during and after reset until an allocation takes effect.
- Preg 0 is hard-wired not busy: never set, always reads 0.
- Responses are combinational, zero latency, and depend only on current state and this cycle's inputs. They do not depend on valid, so a consumer ignores responses for invalid slots.
- Read rule for source s: busy[s] AND NOT (wakeup 0 valid and pdst==s) AND NOT (wakeup 1 valid and pdst==s). This is same-cycle wakeup bypass.
- Intra-bundle rule: each slot-1 source is also busy if slot 0 is valid, has ldst_val set, has pdst==s, and s!=0.
  - This overrides wakeup bypass, because the new producer wins.
  - Slot 0 sources never see slot 1's pdst. A slot never sees its own pdst.
- Allocation: a valid slot with ldst_val set and pdst!=0 sets busy[pdst] at the next clock edge.
- Wakeup: a valid wakeup port with pdst!=0 clears busy[pdst] at the next clock edge.
- Same-preg collisions in one cycle:
  - Allocation and wakeup: allocation wins, bit ends at 1.
  - Both wakeup ports: cleared once.
  - Both slots: set once.
- io_busy_count equals popcount of the busy vector, always exact.
  - Update it incrementally each cycle: add the number of bits going 0->1, subtract the number of bits going 1->0.
  - Duplicates and no-op events do not change the count: allocating an already-busy preg, or waking a non-busy preg.
  - Count never exceeds NUM_PREGS-1, because preg 0 is excluded. No wrap-around.
- No handshake and no backpressure: every input is accepted every cycle.

Decomposition:
- Shared package (issue_pkg): NUM_PREGS, PREG_W, and a preg_t typedef (logic [PREG_W-1:0]). The issue slots import the same package.
- One natural sub-module: busy_read_port. It maps one source preg, the busy vector, and the wakeup ports to a busy bit, and is instantiated 6 times.
- The intra-bundle override stays in the top module.

Test Plan:
1. Reset, then read prs1=5 -> busy 0, io_busy_count=0.
2. Slot 0 allocates pdst=5 in cycle t; slot 0 reads prs1=5 at t+1 -> busy 1 and count=1. Wakeup pdst=5 at t+3 -> same-cycle read busy 0; t+4 count=0.
3. Same cycle: slot 0 allocates pdst=9 and slot 1 reads prs2=9 -> slot-1 prs2_busy=1. Slot 0 reading prs1=9 in that cycle -> 0.
4. busy[12]=1; in one cycle, wakeup port 0 pdst=12 and slot 1 allocates pdst=12 -> next cycle busy[12]=1, count unchanged.
5. Allocate pdst=0, and wake pdst=0 on both ports -> all reads of 0 return 0, count stays 0.
6. Allocate pdst=20 and 21; wake 20 on both ports while re-allocating 21 -> count goes 0, 2, then 1. Assert reset while count=1 -> next cycle count=0 and all busy reads 0.
